// File: rtl/score_bcd_accum.sv
// rtl/score_bcd_accum.sv - 8-digit BCD score accumulator with atomic commit
//
// Adds BCD point awards to an 8-digit score one digit per cycle (ripple carry)
// in a shadow register, then commits the whole result to the digit outputs in
// a single cycle so the display never sees a partially carried value.
//
// Ports:
//   clk_1MHz              system clock, rising edge
//   rst                   asynchronous active-low reset
//   clr                   synchronous score clear (beats add_valid)
//   add_valid/add_ready   award handshake; transfer when both high
//   add_pts               award, 4*ADD_DIGITS bits BCD, [3:0] = units
//   busy                  high in ADD and COMMIT
//   ovf                   overflow indication
//   digit1out..digit8out  committed score, digit1out = least significant
//
// Optional feature macro: SCORE_SAT_EN
//   defined   : saturate at 99999999, ovf sticky until clr/reset
//   undefined : wrap modulo 10^8, ovf pulses for one cycle after COMMIT

module score_bcd_accum #(
  parameter int ADD_DIGITS = 2
) (
  input  logic                    clk_1MHz,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    add_valid,
  input  logic [4*ADD_DIGITS-1:0] add_pts,
  output logic                    add_ready,
  output logic                    busy,
  output logic                    ovf,
  output logic [3:0]              digit1out,
  output logic [3:0]              digit2out,
  output logic [3:0]              digit3out,
  output logic [3:0]              digit4out,
  output logic [3:0]              digit5out,
  output logic [3:0]              digit6out,
  output logic [3:0]              digit7out,
  output logic [3:0]              digit8out
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_COMMIT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_shadow;
  logic [31:0] r_award;
  logic [31:0] r_digits;
  logic [2:0]  r_idx;
  logic        r_carry;
  logic        r_ovf;

  logic [31:0] w_award;
  logic [3:0]  w_sh_dig;
  logic [3:0]  w_aw_dig;
  logic [4:0]  w_sum;
  logic [3:0]  w_dig_next;

  // Award widened to 8 digits: each supplied nibble clamped to 9, upper
  // digits beyond ADD_DIGITS forced to 0.
  genvar g;
  for (g = 0; g < 8; g++) begin : g_award
    if (g < ADD_DIGITS) begin : g_in
      assign w_award[4*g +: 4] = (add_pts[4*g +: 4] > 4'd9) ? 4'd9 : add_pts[4*g +: 4];
    end else begin : g_pad
      assign w_award[4*g +: 4] = 4'd0;
    end
  end

  assign w_sh_dig = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_aw_dig = r_award[{r_idx, 2'b00} +: 4];
  assign w_sum    = {1'b0, w_sh_dig} + {1'b0, w_aw_dig} + {4'd0, r_carry};
  // Sum is at most 19; subtracting 10 on the low nibble is exact modulo 16.
  assign w_dig_next = (w_sum > 5'd9) ? (w_sum[3:0] - 4'd10) : w_sum[3:0];

  // State register
  always_ff @(posedge clk_1MHz or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (add_valid) w_state_next = S_ADD;
        S_ADD:    if (r_idx == 3'd7) w_state_next = S_COMMIT;
        S_COMMIT: w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    add_ready = 1'b0;
    busy      = 1'b1;
    if (r_state == S_IDLE) begin
      add_ready = 1'b1;
      busy      = 1'b0;
    end
  end

  // Datapath
  always_ff @(posedge clk_1MHz or negedge rst) begin
    if (!rst) begin
      r_shadow <= 32'd0;
      r_award  <= 32'd0;
      r_digits <= 32'd0;
      r_idx    <= 3'd0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (clr) begin
      r_shadow <= 32'd0;
      r_award  <= 32'd0;
      r_digits <= 32'd0;
      r_idx    <= 3'd0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
`ifndef SCORE_SAT_EN
      r_ovf <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (add_valid) begin
            r_award  <= w_award;
            r_shadow <= r_digits;
            r_idx    <= 3'd0;
            r_carry  <= 1'b0;
          end
        end
        S_ADD: begin
          r_shadow[{r_idx, 2'b00} +: 4] <= w_dig_next;
          r_carry <= (w_sum > 5'd9);
          r_idx   <= r_idx + 3'd1;
        end
        S_COMMIT: begin
`ifdef SCORE_SAT_EN
          // Once overflowed, every later award pins the score at all nines.
          if (r_carry || r_ovf) begin
            r_digits <= {8{4'd9}};
            r_ovf    <= 1'b1;
          end else begin
            r_digits <= r_shadow;
          end
`else
          r_digits <= r_shadow;
          r_ovf    <= r_carry;
`endif
        end
        default: ;
      endcase
    end
  end

  assign ovf       = r_ovf;
  assign digit1out = r_digits[3:0];
  assign digit2out = r_digits[7:4];
  assign digit3out = r_digits[11:8];
  assign digit4out = r_digits[15:12];
  assign digit5out = r_digits[19:16];
  assign digit6out = r_digits[23:20];
  assign digit7out = r_digits[27:24];
  assign digit8out = r_digits[31:28];

endmodule

// File: tb/tb_score_bcd_accum.sv
// tb/tb_score_bcd_accum.sv - scoreboard bench for score_bcd_accum
`timescale 1ns/1ps

module tb_score_bcd_accum;

  localparam int AD = 7;
`ifdef SCORE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk_1MHz = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          add_valid = 1'b0;
  logic [4*AD-1:0] add_pts = '0;
  logic          add_ready, busy, ovf;
  logic [3:0]    digit1out, digit2out, digit3out, digit4out;
  logic [3:0]    digit5out, digit6out, digit7out, digit8out;
  logic [31:0]   w_dig;

  assign w_dig = {digit8out, digit7out, digit6out, digit5out,
                  digit4out, digit3out, digit2out, digit1out};

  score_bcd_accum #(.ADD_DIGITS(AD)) u_dut (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .clr      (clr),
    .add_valid(add_valid),
    .add_pts  (add_pts),
    .add_ready(add_ready),
    .busy     (busy),
    .ovf      (ovf),
    .digit1out(digit1out),
    .digit2out(digit2out),
    .digit3out(digit3out),
    .digit4out(digit4out),
    .digit5out(digit5out),
    .digit6out(digit6out),
    .digit7out(digit7out),
    .digit8out(digit8out)
  );

  always #500 clk_1MHz = ~clk_1MHz;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk_1MHz) cyc <= cyc + 1;

  typedef struct {
    longint score;
    bit     ovf;
    bit     lat;
    int     acc;
  } exp_t;

  exp_t   q[$];
  longint m_score = 0;
  bit     m_sat = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint shown();
    longint v = 0;
    longint p = 1;
    for (int i = 0; i < 8; i++) begin
      v += longint'(w_dig[4*i +: 4]) * p;
      p *= 10;
    end
    return v;
  endfunction

  // Reference: award value in decimal, score as a plain integer.
  task automatic model_accept(input logic [4*AD-1:0] pts);
    longint aw = 0;
    longint p = 1;
    longint ns;
    int d;
    exp_t e;
    for (int i = 0; i < AD; i++) begin
      d = int'(pts[4*i +: 4]);
      if (d > 9) d = 9;
      aw += longint'(d) * p;
      p *= 10;
    end
    ns = m_score + aw;
    if (SAT) begin
      if (ns >= 100000000 || m_sat) begin
        m_score = 99999999;
        m_sat = 1;
      end else begin
        m_score = ns;
      end
      e.ovf = m_sat;
    end else begin
      e.ovf = (ns >= 100000000);
      m_score = ns % 100000000;
    end
    e.score = m_score;
    e.lat = 1;
    e.acc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic push_abort();
    exp_t z;
    z.score = 0;
    z.ovf = 0;
    z.lat = 0;
    z.acc = 0;
    q.delete();
    q.push_back(z);
  endtask

  // Monitor: pops an expectation whenever busy falls.
  logic        prev_busy = 1'b0;
  logic [31:0] prev_dig = '0;
  bit          pend = 0;
  bit          pend_val = 0;
  exp_t        mon_e;

  always @(negedge clk_1MHz) begin
    if (pend) begin
      chk("ovf_next_cycle", ovf, pend_val);
      pend = 0;
    end
    if (prev_busy && !busy) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got completion expected none");
      end else begin
        mon_e = q.pop_front();
        chk("digits", shown(), mon_e.score);
        chk("ovf", ovf, mon_e.ovf);
        chk("ready_back", add_ready, 1);
        if (mon_e.lat) chk("latency", cyc - mon_e.acc, 9);
        pend = 1;
        pend_val = SAT ? mon_e.ovf : 1'b0;
      end
    end
    if (prev_busy && busy) chk("stable_during_add", w_dig, prev_dig);
    prev_busy = busy;
    prev_dig = w_dig;
  end

  task automatic drive_valid(input logic [4*AD-1:0] pts, input int n, output int acc);
    acc = 0;
    add_pts = pts;
    add_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (add_ready && !clr) begin
        model_accept(pts);
        acc++;
      end
      @(negedge clk_1MHz);
    end
    add_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk_1MHz);
      t++;
    end
    chk("idle_timeout", busy, 0);
    @(negedge clk_1MHz);
  endtask

  task automatic award(input logic [4*AD-1:0] pts);
    int a;
    drive_valid(pts, 1, a);
    chk("accepted", a, 1);
    wait_idle();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    if (busy) push_abort();
    @(negedge clk_1MHz);
    clr = 1'b0;
    m_score = 0;
    m_sat = 0;
    chk("clr_ready", add_ready, 1);
    chk("clr_digits", shown(), 0);
    chk("clr_ovf", ovf, 0);
  endtask

  initial begin
    int a;
    logic [4*AD-1:0] r;
    #100 rst = 1'b0;
    repeat (2) @(negedge clk_1MHz);
    chk("rst_digits", shown(), 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", add_ready, 1);
    rst = 1'b1;
    @(negedge clk_1MHz);

    // basic add
    award(28'h45);
    chk("basic_45", shown(), 45);

    // ripple carry
    do_clr();
    award(28'h0999999);
    award(28'h01);
    chk("ripple", shown(), 1000000);

    // overflow
    do_clr();
    for (int i = 0; i < 10; i++) award(28'h9999999);
    chk("pre_ovf", shown(), 99999990);
    award(28'h15);
    award(28'h01);
    chk("post_ovf2", shown(), SAT ? 64'd99999999 : 64'd6);

    // clr clears ovf and score
    do_clr();

    // clr beats add_valid on the same edge
    clr = 1'b1;
    add_valid = 1'b1;
    add_pts = 28'h77;
    @(negedge clk_1MHz);
    clr = 1'b0;
    add_valid = 1'b0;
    repeat (2) @(negedge clk_1MHz);
    chk("clr_valid_busy", busy, 0);
    chk("clr_valid_digits", shown(), 0);

    // clr during ADD
    award(28'h12);
    drive_valid(28'h33, 1, a);
    repeat (3) @(negedge clk_1MHz);
    chk("busy_before_clr", busy, 1);
    do_clr();
    wait_idle();

    // clamp and back-pressure
    drive_valid(28'hFA, 25, a);
    chk("bp_accepts", a, 3);
    wait_idle();
    chk("bp_score", shown(), 297);

    // zero award still runs the full sequence
    award(28'h0);
    chk("zero_award", shown(), 297);

    // randomized
    for (int it = 0; it < 40; it++) begin
      r = 28'($urandom);
      if ($urandom_range(0, 1) == 1) r = r & 28'h00000FF;
      drive_valid(r, $urandom_range(1, 3), a);
      repeat ($urandom_range(0, 12)) @(negedge clk_1MHz);
      if ($urandom_range(0, 5) == 0) do_clr();
      wait_idle();
    end

    // reset mid-addition
    drive_valid(28'h55, 1, a);
    repeat (3) @(negedge clk_1MHz);
    chk("busy_before_rst", busy, 1);
    push_abort();
    #200 rst = 1'b0;
    #10;
    chk("async_rst_digits", shown(), 0);
    chk("async_rst_ovf", ovf, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", add_ready, 1);
    @(negedge clk_1MHz);
    rst = 1'b1;
    m_score = 0;
    m_sat = 0;
    @(negedge clk_1MHz);
    award(28'h21);
    chk("after_rst", shown(), 21);

    repeat (2) @(negedge clk_1MHz);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/score_bcd_accum.md
Name: score_bcd_accum

Overview:
- Upstream producer of the 8-digit BCD game score.
- Accepts point-award requests over a valid/ready handshake and adds the award to a shadow 8-digit BCD score, one digit per cycle with ripple carry.
- Commits the result atomically to its digit outputs, which feed the score display register stage.
- Outputs never show a partially carried sum.

Parameters:
- ADD_DIGITS, 2, number of BCD digits in add_pts (1..8); add_pts width is 4*ADD_DIGITS.

Ports:
- clk_1MHz  input  1  1 MHz system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- clr  input  1  synchronous score clear request
- add_valid  input  1  award request valid
- add_pts  input  4*ADD_DIGITS  award in BCD; nibble [3:0] = units
- add_ready  output  1  block can accept an award this cycle
- busy  output  1  addition in progress (ADD or COMMIT state)
- ovf  output  1  overflow indication (see Optional Feature)
- digit1out..digit8out  output  4 each  committed score in BCD; digit1out = least significant

Behaviour:
- Reset (rst=0, asynchronous): every output goes to 0 except add_ready, which goes to 1. This covers digit1out..digit8out, busy and ovf. Shadow score, carry, digit index and latched award are cleared. FSM goes to IDLE.
- FSM states: IDLE, ADD, COMMIT.
- IDLE:
  - add_ready=1 and busy=0.
  - A transfer occurs on the edge where add_valid=1 and add_ready=1.
  - On transfer: latch add_pts, copy the committed digits into the shadow, set index=0 and carry=0, go to ADD.
- ADD:
  - One digit per cycle, index 0..7.
  - Per cycle: s = shadow[idx] + award[idx] + carry. award[idx] is 0 for idx >= ADD_DIGITS.
  - If s > 9: shadow[idx] = s-10 and carry = 1. Otherwise shadow[idx] = s and carry = 0.
  - Sums use 5-bit intermediate width.
  - After idx=7, go to COMMIT. ADD always lasts exactly 8 cycles; there is no early exit.
- COMMIT (1 cycle):
  - digit outputs <= shadow.
  - Final carry is resolved per the Optional Feature.
  - Then return to IDLE.
- Latency and throughput:
  - The accept edge is edge 0. Digit outputs change on edge 9.
  - add_ready returns to 1 after edge 9, so the next accept can occur on edge 10.
  - Throughput is 1 award per 10 cycles.
- add_ready=0 and busy=1 throughout ADD and COMMIT. add_valid is ignored while not ready; the requester must hold it.
- An award nibble with value >9 is clamped to 9 when latched.
- Award of 0 runs the full sequence; outputs are unchanged and add_ready still drops for 10 cycles.
- clr:
  - In any state, sampled high on an edge: all digit outputs and the shadow go to 0, ovf goes to 0, FSM goes to IDLE.
  - An in-flight addition is discarded.
  - clr beats add_valid in the same cycle; no transfer occurs.
- Reset asserted mid-addition aborts immediately to the reset values above.
- Digit inputs to the adder are always valid BCD. There is no path that produces 10..15 on any digit output.

Optional Feature:
- Macro: SCORE_SAT_EN.
- Defined (saturating):
  - A final carry at COMMIT forces all 8 outputs to 9 (99999999).
  - ovf is set and stays 1 (sticky) until clr or reset.
  - While ovf=1, further awards are still accepted but leave the score at 99999999.
- Undefined (wrapping):
  - The score wraps modulo 10^8; outputs take the shadow value.
  - ovf pulses high for exactly the one cycle following a COMMIT that produced a final carry, and is 0 otherwise.

Test Plan:
- Reset: rst=0 mid-run at any time -> all digits 0, ovf=0, busy=0, add_ready=1 asynchronously, before the next clock edge.
- Basic add: score 00000000, add_pts=8'h45 -> digits read 00000045 exactly 9 edges after accept; add_ready high again 10 cycles after accept.
- Ripple carry: score 00999999, add_pts=8'h01 -> 01000000; no intermediate value visible on the outputs during ADD.
- Overflow:
  - Score 99999990, add_pts=8'h15.
  - With SCORE_SAT_EN -> 99999999 and ovf=1 sticky; a second add of 8'h01 keeps 99999999.
  - Without -> 00000005 and a one-cycle ovf pulse.
- Clear priority: clr=1 on the same edge as add_valid=1 -> no transfer, digits 0; clr during ADD -> abort, digits 0, add_ready=1 the next cycle.
- Clamp and back-pressure: add_pts=8'hFA held with add_valid during busy -> treated as 99 and accepted only once per 10-cycle window; score 0 becomes 00000099.
